array_responder: RTL and testbench
==================================

// Module: array_responder
// PURPOSE
// Responder end of the array command interface (op_code/addr/data_bank/data_in).
// Holds DEPTH x DATA_W storage with per-row valid bits and executes commands:
//   - write and read complete in one cycle.
//   - masked search scans rows sequentially and reports first match and match count.
// Sits below the command source in the bench and in synthesis; it is the
// behavioural/RTL counterpart the stimulus drives.
// PARAMETERS
// DATA_W  16   row width (bits)
// ADDR_W  9    address width
// DEPTH   512  number of rows (<= 2**ADDR_W)
// PORTS
// clk        in   1         clock; all state on rising edge
// rst        in   1         async active-high reset
// cmd_valid  in   1         command present
// cmd_ready  out  1         responder can accept
// op_code    in   2         00 read, 01 write, 10 search, 11 nop
// addr       in   ADDR_W    row address (read/write); start row (search)
// data_bank  in   DATA_W    write data (write); search key (search)
// data_in    in   DATA_W    read mask (read); compare mask, 1 = compare bit (search)
// rsp_valid  out  1         one-cycle response pulse
// rsp_data   out  DATA_W    read result
// rsp_hit    out  1         search: >=1 match found
// rsp_addr   out  ADDR_W    search: lowest matching row >= start
// rsp_count  out  ADDR_W+1  search: number of matching rows
// BEHAVIOUR
// - Accept when cmd_valid && cmd_ready. cmd_ready = (state==IDLE) && !rst.
// - Reset values:
//     state = IDLE; all valid bits = 0; rsp_* = 0.
//     Storage array itself is not reset.
// - Write: mem[addr] <= data_bank, valid[addr] <= 1. Response next cycle with
//   rsp_valid=1 and all other rsp_* = 0.
// - Read: next cycle rsp_valid=1, rsp_data = valid[addr] ? (mem[addr] & data_in) : 0.
//   Search fields are 0.
// - Nop: accepted, no response, no state change.
// - Out-of-range addr (>= DEPTH): write is dropped; read returns 0; search returns
//   hit=0, count=0. Each still responds one cycle later.
// - Search FSM, states IDLE -> SCAN -> IDLE:
//     * On accept, latch key, mask and start; ptr = addr; cnt = 0; found = 0.
//     * SCAN evaluates one row per cycle:
//         match = valid[ptr] && (((mem[ptr] ^ key) & mask) == 0).
//     * On the first match, latch ptr as rsp_addr. cnt increments on each match.
//     * Last row is DEPTH-1. Response comes the cycle after the last row is
//       evaluated. Latency from accept to rsp_valid = DEPTH - addr + 1 cycles.
//     * mask = 0 matches every valid row.
// - rsp_valid is a single-cycle pulse with no backpressure.
//   rsp_data/hit/addr/count hold their values until the next response.
// - cmd_ready is low for the whole of SCAN. It returns high in the cycle
//   rsp_valid pulses, so a back-to-back command can be accepted in that cycle.
// - Reset asserted mid-search: scan aborts, no response is issued, and valid bits
//   are cleared.
// - Width: cnt saturates naturally. Max count is DEPTH, which fits ADDR_W+1 bits.
// TESTING
// 1 Reset, read addr 0 with data_in=16'h00FF:
//   -> rsp_valid after 1 cycle, rsp_data=16'h0000.
// 2 Write addr 0 with data_bank=16'h00FF, then read addr 0 with data_in=16'h00FF:
//   -> rsp_data=16'h00FF. Read addr 2 -> 16'h0000 (unwritten row).
// 3 Write addr 1 with data_bank=16'h00AA, then read addr 1 with data_in=16'h000F:
//   -> rsp_data=16'h000A.
// 4 After tests 2 and 3, search addr 0, data_bank=16'h0001, data_in=16'h0001:
//   -> rsp_hit=1, rsp_addr=0, rsp_count=1, rsp_valid exactly 513 cycles after accept.
//   Same search with start addr 1 -> hit=0, count=0, latency 512 cycles.
// 5 Search with data_in=16'h0000 after two writes:
//   -> count=2. cmd_ready stays low throughout SCAN; a held cmd_valid is accepted in
//      the rsp_valid cycle.
// 6 Assert rst during SCAN:
//   -> no rsp_valid is issued. A subsequent read of addr 0 returns 16'h0000.

Source files
------------

// File: rtl/array_responder.sv
// Responder end of the array command interface: DEPTH x DATA_W row storage with
// per-row valid bits, single-cycle read/write and a sequential masked search.
module array_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        op_code,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_bank,
  input  logic [DATA_W-1:0] data_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [ADDR_W:0]   rsp_count
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                found_q, found_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic [ADDR_W:0]     rsp_count_q, rsp_count_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic                accept;
  logic                in_range;
  logic                match;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = ({1'b0, addr} < DEPTH_W);
  assign match     = valid_q[ptr_q] && (((mem[ptr_q] ^ key_q) & mask_q) == '0);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    first_d     = first_q;
    key_d       = key_q;
    mask_d      = mask_q;
    valid_d     = valid_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_count_d = rsp_count_q;
    mem_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          // Everything except nop and an in-range search answers next cycle.
          if (op_code != OP_NOP && !(op_code == OP_SEARCH && in_range)) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_hit_d   = 1'b0;
            rsp_addr_d  = '0;
            rsp_count_d = '0;
          end
          unique case (op_code)
            OP_READ: begin
              if (in_range && valid_q[addr]) rsp_data_d = mem[addr] & data_in;
            end
            OP_WRITE: begin
              if (in_range) begin
                mem_we        = 1'b1;
                valid_d[addr] = 1'b1;
              end
            end
            OP_SEARCH: begin
              if (in_range) begin
                key_d   = data_bank;
                mask_d  = data_in;
                ptr_d   = addr;
                cnt_d   = '0;
                found_d = 1'b0;
                state_d = SCAN;
              end
            end
            default: ;
          endcase
        end
      end
      SCAN: begin
        if (match) begin
          cnt_d = cnt_q + 1'b1;
          if (!found_q) begin
            found_d = 1'b1;
            first_d = ptr_q;
          end
        end
        if (ptr_q == LAST_ROW) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_hit_d   = found_d;
          rsp_addr_d  = found_d ? first_d : '0;
          rsp_count_d = cnt_d;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      first_q     <= '0;
      key_q       <= '0;
      mask_q      <= '0;
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      found_q     <= found_d;
      first_q     <= first_d;
      key_q       <= key_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_count_q <= rsp_count_d;
    end
  end

  // Row storage is deliberately not reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= data_bank;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_array_responder.sv
// Scoreboard bench for array_responder: a behavioural row model predicts each
// response at accept time; a negedge monitor pops and compares it.
module tb_array_responder;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    op_code;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_bank;
  logic [DW-1:0] data_in;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_hit;
  logic [AW-1:0] rsp_addr;
  logic [AW:0]   rsp_count;

  array_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op_code   (op_code),
    .addr      (addr),
    .data_bank (data_bank),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_hit   (rsp_hit),
    .rsp_addr  (rsp_addr),
    .rsp_count (rsp_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          hit;
    logic [AW-1:0] addr;
    logic [AW:0]   count;
    int            acc;
    int            lat;
    bit            srch;
  } exp_t;

  exp_t          sb[$];
  exp_t          me;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  logic [DW-1:0] last_data;
  logic          last_hit;
  logic [AW-1:0] last_addr;
  logic [AW:0]   last_count;
  int            last_lat;
  logic [AW:0]   last_srch_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      n_rsp++;
      chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        chk("rsp_data",    32'(rsp_data),  32'(me.data));
        chk("rsp_hit",     32'(rsp_hit),   32'(me.hit));
        chk("rsp_addr",    32'(rsp_addr),  32'(me.addr));
        chk("rsp_count",   32'(rsp_count), 32'(me.count));
        chk("rsp_latency", 32'(cyc - me.acc), 32'(me.lat));
        last_data  = rsp_data;
        last_hit   = rsp_hit;
        last_addr  = rsp_addr;
        last_count = rsp_count;
        last_lat   = cyc - me.acc;
        if (me.srch) last_srch_count = rsp_count;
      end
    end
  end

  // Drives a command, holds it until accepted, and pushes the predicted response.
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] m,
                      output int acc, output int waits);
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    op_code   = op;
    addr      = a;
    data_bank = b;
    data_in   = m;
    waits     = 0;
    while (!cmd_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc     = cyc;
    e.data  = '0;
    e.hit   = 1'b0;
    e.addr  = '0;
    e.count = '0;
    e.acc   = cyc;
    e.lat   = 1;
    e.srch  = 1'b0;
    case (op)
      2'b00: begin
        if (m_val[a]) e.data = m_mem[a] & m;
        sb.push_back(e);
      end
      2'b01: begin
        m_mem[a] = b;
        m_val[a] = 1'b1;
        sb.push_back(e);
      end
      2'b10: begin
        for (int i = int'(a); i < DEPTH; i++) begin
          if (m_val[i] && (((m_mem[i] ^ b) & m) == '0)) begin
            if (!e.hit) e.addr = AW'(i);
            e.hit   = 1'b1;
            e.count = e.count + 1'b1;
          end
        end
        e.lat  = DEPTH - int'(a) + 1;
        e.srch = 1'b1;
        sb.push_back(e);
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_s, acc_r, w, saved;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    op_code   = 2'b11;
    addr      = '0;
    data_bank = '0;
    data_in   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = 1'b0;
      m_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  32'(rsp_data),  32'd0);
    chk("reset_rsp_hit",   32'(rsp_hit),   32'd0);
    chk("reset_rsp_addr",  32'(rsp_addr),  32'd0);
    chk("reset_rsp_count", 32'(rsp_count), 32'd0);
    chk("reset_ready_low", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    send(2'b00, 9'd0, 16'h0000, 16'h00FF, acc_r, w);
    drain();
    chk("t1_read_empty", 32'(last_data), 32'h0000);
    chk("t1_latency",    32'(last_lat),  32'd1);

    send(2'b01, 9'd0, 16'h00FF, 16'h0000, acc_r, w);
    send(2'b00, 9'd0, 16'h0000, 16'h00FF, acc_r, w);
    drain();
    chk("t2_read_row0", 32'(last_data), 32'h00FF);
    send(2'b00, 9'd2, 16'h0000, 16'hFFFF, acc_r, w);
    drain();
    chk("t2_read_unwritten", 32'(last_data), 32'h0000);

    send(2'b01, 9'd1, 16'h00AA, 16'h0000, acc_r, w);
    send(2'b00, 9'd1, 16'h0000, 16'h000F, acc_r, w);
    drain();
    chk("t3_read_masked", 32'(last_data), 32'h000A);

    send(2'b10, 9'd0, 16'h0001, 16'h0001, acc_s, w);
    drain();
    chk("t4_hit",     32'(last_hit),   32'd1);
    chk("t4_addr",    32'(last_addr),  32'd0);
    chk("t4_count",   32'(last_count), 32'd1);
    chk("t4_latency", 32'(last_lat),   32'd513);
    send(2'b10, 9'd1, 16'h0001, 16'h0001, acc_s, w);
    drain();
    chk("t4b_hit",     32'(last_hit),   32'd0);
    chk("t4b_count",   32'(last_count), 32'd0);
    chk("t4b_latency", 32'(last_lat),   32'd512);

    // Search with mask 0, then a read held during the whole scan.
    send(2'b10, 9'd0, 16'h1234, 16'h0000, acc_s, w);
    send(2'b00, 9'd1, 16'h0000, 16'hFFFF, acc_r, w);
    chk("t5_ready_low_cycles", 32'(w), 32'd512);
    chk("t5_back_to_back",     32'(acc_r - acc_s), 32'd513);
    drain();
    chk("t5_count", 32'(last_srch_count), 32'd2);
    chk("t5_read",  32'(last_data), 32'h00AA);

    send(2'b11, 9'd3, 16'hFFFF, 16'hFFFF, acc_r, w);
    repeat (3) @(negedge clk);
    chk("nop_no_rsp", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]    op;
      logic [AW-1:0] a;
      op = 2'($urandom_range(0, 3));
      a  = (op == 2'b10) ? AW'($urandom_range(490, 511)) : AW'($urandom_range(0, 15));
      send(op, a, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), acc_r, w);
    end
    send(2'b01, 9'd505, 16'hBEEF, 16'h0000, acc_r, w);
    send(2'b10, 9'd500, 16'hBE00, 16'hFF00, acc_s, w);
    drain();

    send(2'b10, 9'd0, 16'h0000, 16'h0000, acc_s, w);
    repeat (100) @(negedge clk);
    saved = n_rsp;
    apply_reset();
    repeat (600) @(negedge clk);
    chk("t6_no_rsp_after_rst", 32'(n_rsp), 32'(saved));
    send(2'b00, 9'd0, 16'h0000, 16'hFFFF, acc_r, w);
    drain();
    chk("t6_read_cleared", 32'(last_data), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
